// File: rtl/gd_step_sat.sv
// gd_step_sat: one gradient-descent step per channel, x_next = sat(x - (grad >>> lr_shift)).
// Two-stage valid/ready pipeline (shift stage, subtract/saturate stage) with per-channel
// saturation flags, a convergence indicator and a sticky count of saturating results.
module gd_step_sat #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int CH    = 4,
   parameter int EPS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CH*WIDTH-1:0]   x_in,
   input  logic [CH*WIDTH-1:0]   grad_in,
   input  logic [3:0]            lr_shift,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CH*WIDTH-1:0]   next_out,
   output logic [CH-1:0]         overflow,
   output logic [CH-1:0]         underflow,
   output logic                  converged,
   output logic [15:0]           sat_count,
   input  logic                  sat_clr
);

   // The datapath is format-agnostic; FRAC only documents the operand format,
   // but a nonsensical split is rejected at elaboration.
   if (FRAC < 0 || FRAC >= WIDTH) begin : g_frac_check
      $error("gd_step_sat: FRAC must lie in [0, WIDTH-1]");
   end

   // Threshold widened to the magnitude width so |-2^(WIDTH-1)| compares without wrap.
   localparam logic [WIDTH:0] L_EPS = (WIDTH+1)'(EPS);

   logic                 w_s1_adv;
   logic                 w_s2_adv;
   logic                 w_out_xfer;
   logic                 w_any_sat;
   logic [CH*WIDTH-1:0]  w_step;
   logic [CH*WIDTH-1:0]  w_sat;
   logic [CH-1:0]        w_ov;
   logic [CH-1:0]        w_uf;
   logic [CH-1:0]        w_ch_conv;

   logic                 r_s1_valid;
   logic [CH*WIDTH-1:0]  r_s1_x;
   logic [CH*WIDTH-1:0]  r_s1_step;
   logic                 r_s2_valid;
   logic [CH*WIDTH-1:0]  r_next_out;
   logic [CH-1:0]        r_ov;
   logic [CH-1:0]        r_uf;
   logic                 r_conv;
   logic [15:0]          r_sat_count;

   // Backpressure ripples combinationally from out_ready; no skid buffer.
   assign w_s2_adv   = ~r_s2_valid | out_ready;
   assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
   assign in_ready   = w_s1_adv;
   assign w_out_xfer = r_s2_valid & out_ready;
   assign w_any_sat  = |(r_ov | r_uf);

   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_ch
         logic signed [WIDTH-1:0] w_grad_k;
         logic [WIDTH:0]          w_step_ext;
         logic [WIDTH:0]          w_abs;
         logic [WIDTH:0]          w_x_ext;
         logic [WIDTH:0]          w_diff;

         // Arithmetic shift floors toward minus infinity; large shifts collapse to 0 / -1.
         assign w_grad_k = grad_in[gi*WIDTH +: WIDTH];
         assign w_step[gi*WIDTH +: WIDTH] = w_grad_k >>> lr_shift;

         // Stage-2 arithmetic works on the registered stage-1 values, one bit wider.
         assign w_step_ext = {r_s1_step[gi*WIDTH+WIDTH-1], r_s1_step[gi*WIDTH +: WIDTH]};
         assign w_x_ext    = {r_s1_x[gi*WIDTH+WIDTH-1], r_s1_x[gi*WIDTH +: WIDTH]};
         assign w_abs      = w_step_ext[WIDTH] ? (~w_step_ext + 1'b1) : w_step_ext;
         assign w_ch_conv[gi] = (w_abs <= L_EPS);

         // Top two bits of the wide difference disagree exactly when it leaves the WIDTH range.
         assign w_diff   = w_x_ext - w_step_ext;
         assign w_ov[gi] = ~w_diff[WIDTH] &  w_diff[WIDTH-1];
         assign w_uf[gi] =  w_diff[WIDTH] & ~w_diff[WIDTH-1];
         assign w_sat[gi*WIDTH +: WIDTH] = w_ov[gi] ? {1'b0, {(WIDTH-1){1'b1}}} :
                                           w_uf[gi] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                                      w_diff[WIDTH-1:0];
      end
   endgenerate

   // Stage 1: capture the point and the shifted step when the stage can advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_x     <= '0;
         r_s1_step  <= '0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_x    <= x_in;
            r_s1_step <= w_step;
         end
      end
   end

   // Stage 2: saturated result, flags and convergence; frozen while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_next_out <= '0;
         r_ov       <= '0;
         r_uf       <= '0;
         r_conv     <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_next_out <= w_sat;
            r_ov       <= w_ov;
            r_uf       <= w_uf;
            r_conv     <= &w_ch_conv;
         end
      end
   end

   // Sticky saturation counter; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sat_count <= '0;
      end else if (sat_clr) begin
         r_sat_count <= '0;
      end else if (w_out_xfer && w_any_sat && (r_sat_count != 16'hFFFF)) begin
         r_sat_count <= r_sat_count + 16'd1;
      end
   end

   assign out_valid = r_s2_valid;
   assign next_out  = r_next_out;
   assign overflow  = r_ov;
   assign underflow = r_uf;
   assign converged = r_conv;
   assign sat_count = r_sat_count;

endmodule

// File: tb/tb_gd_step_sat.sv
// Scoreboard bench for gd_step_sat: directed vectors push hand-computed results,
// a forked monitor compares every presented output (including stalled cycles).
module tb_gd_step_sat;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] x_in = '0;
   logic [63:0] grad_in = '0;
   logic [3:0]  lr_shift = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] next_out;
   logic [3:0]  overflow;
   logic [3:0]  underflow;
   logic        converged;
   logic [15:0] sat_count;
   logic        sat_clr = 1'b0;

   always #5 clk = ~clk;

   gd_step_sat #(.WIDTH(16), .FRAC(8), .CH(4), .EPS(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .grad_in(grad_in), .lr_shift(lr_shift),
      .out_valid(out_valid), .out_ready(out_ready),
      .next_out(next_out), .overflow(overflow), .underflow(underflow),
      .converged(converged), .sat_count(sat_count), .sat_clr(sat_clr)
   );

   typedef struct {
      logic [63:0] nx;
      logic [3:0]  ov;
      logic [3:0]  uf;
      logic        cv;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 2;   // 0: always ready, 1: toggle each cycle, 2: stalled
   bit   bulk = 1'b0;
   int   n_out = 0;

   function automatic logic [63:0] rep4(input logic [15:0] w);
      return {w, w, w, w};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   // Present one vector starting at posedge+1; expectation is queued on the accepting edge.
   task automatic send(input logic [63:0] x, input logic [63:0] g, input logic [3:0] lr,
                       input logic [63:0] nx, input logic [3:0] ov, input logic [3:0] uf,
                       input logic cv);
      exp_t e;
      bit   acc;
      int   n;
      e.nx = nx; e.ov = ov; e.uf = uf; e.cv = cv;
      in_valid = 1'b1; x_in = x; grad_in = g; lr_shift = lr;
      acc = 1'b0; n = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         n++;
      end
      if (acc) sb.push_back(e);
      else begin
         checks++; errors++;
         $display("FAIL accept_timeout in_ready stayed 0 for %0d cycles, want 1", n);
      end
      #1;
      in_valid = 1'b0;
      $display("sent x=%h grad=%h lr=%0d expect next=%h ov=%b uf=%b conv=%b", x, g, lr, nx, ov, uf, cv);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, 64'(sb.size()), 64'd0);
   endtask

   logic [63:0] sv_x, sv_n;
   int          n0;

   initial begin
      fork
         // Monitor: every presented output is compared against the queue head.
         forever begin : mon
            exp_t e;
            @(negedge clk);
            if (!rst && !bulk && out_valid) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_output next_out=%h with empty scoreboard, want no out_valid", next_out);
               end else begin
                  e = sb[0];
                  if (next_out !== e.nx || overflow !== e.ov || underflow !== e.uf || converged !== e.cv) begin
                     errors++;
                     $display("FAIL out%0d got next=%h ov=%b uf=%b conv=%b want next=%h ov=%b uf=%b conv=%b",
                              n_out, next_out, overflow, underflow, converged, e.nx, e.ov, e.uf, e.cv);
                  end else if (out_ready) begin
                     $display("out%0d next=%h ov=%b uf=%b conv=%b ok", n_out, next_out, overflow, underflow, converged);
                  end
                  if (out_ready) begin
                     void'(sb.pop_front());
                     n_out++;
                  end
               end
            end
         end
         // Downstream ready pattern, updated just after each rising edge.
         forever begin : rdy
            @(posedge clk);
            #1;
            case (ready_mode)
               0:       out_ready = 1'b1;
               1:       out_ready = ~out_ready;
               default: out_ready = 1'b0;
            endcase
         end
         begin : watchdog
            #1500000;
            $display("FAIL watchdog simulation did not finish, errors=%0d of %0d checks", errors, checks);
            $fatal(1, "watchdog");
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);
      chk("reset_sat_count", 64'(sat_count), 64'd0);
      chk("reset_next_out", next_out, 64'd0);
      chk("reset_flags", 64'({overflow, underflow}), 64'd0);
      chk("reset_converged", 64'(converged), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      ready_mode = 0;
      @(posedge clk);
      #1;

      // Basic step and two-cycle latency
      send(rep4(16'h0100), rep4(16'h0200), 4'd1, rep4(16'h0000), 4'b0000, 4'b0000, 1'b0);
      chk("latency_cycle1", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("latency_cycle2", 64'(out_valid), 64'd1);
      drain("drain_basic");

      // Positive and negative saturation
      send(rep4(16'h7F00), rep4(16'hF000), 4'd0, rep4(16'h7FFF), 4'b1111, 4'b0000, 1'b0);
      send(rep4(16'h8100), rep4(16'h1000), 4'd0, rep4(16'h8000), 4'b0000, 4'b1111, 1'b0);
      drain("drain_sat");
      chk("sat_count_two", 64'(sat_count), 64'd2);

      // Shift edge cases, convergence, mixed channels
      send(rep4(16'h0100), rep4(16'h8000), 4'd15, rep4(16'h0101), 4'b0000, 4'b0000, 1'b1);
      send(rep4(16'h0100), rep4(16'h0001), 4'd0, rep4(16'h00FF), 4'b0000, 4'b0000, 1'b1);
      send(rep4(16'h0100), 64'h0001_0002_0001_0001, 4'd0, 64'h00FF_00FE_00FF_00FF, 4'b0000, 4'b0000, 1'b0);
      send(rep4(16'h0100), rep4(16'h7FFF), 4'd15, rep4(16'h0100), 4'b0000, 4'b0000, 1'b1);
      send(rep4(16'h0100), rep4(16'h0100), 4'd4, rep4(16'h00F0), 4'b0000, 4'b0000, 1'b0);
      send(rep4(16'h0000), rep4(16'hFFF1), 4'd2, rep4(16'h0004), 4'b0000, 4'b0000, 1'b0);
      send(64'h0000_1234_8100_7F00, 64'h8000_0010_1000_F000, 4'd0,
           64'h7FFF_1224_8000_7FFF, 4'b1001, 4'b0010, 1'b0);
      drain("drain_edges");
      chk("sat_count_three", 64'(sat_count), 64'd3);

      // Stream of 8 with out_ready toggling
      ready_mode = 1;
      n0 = n_out;
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 4; k++) begin
            sv_x[k*16 +: 16] = 16'h1000 + 16'(i) * 16'h0100 + 16'(k);
            sv_n[k*16 +: 16] = 16'h1000 + 16'(i) * 16'h0100 + 16'(k) - 16'h0001;
         end
         send(sv_x, rep4(16'h0010), 4'd4, sv_n, 4'b0000, 4'b0000, 1'b1);
      end
      drain("drain_stream");
      chk("stream_count", 64'(n_out - n0), 64'd8);

      // Saturating traffic drives sat_count to its ceiling
      ready_mode = 0;
      @(posedge clk);
      #1;
      bulk = 1'b1;
      in_valid = 1'b1; x_in = rep4(16'h7F00); grad_in = rep4(16'hF000); lr_shift = 4'd0;
      repeat (65540) @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bulk = 1'b0;
      chk("sat_count_ceiling", 64'(sat_count), 64'hFFFF);
      send(rep4(16'h7F00), rep4(16'hF000), 4'd0, rep4(16'h7FFF), 4'b1111, 4'b0000, 1'b0);
      drain("drain_ceiling");
      chk("sat_count_sticky", 64'(sat_count), 64'hFFFF);

      // sat_clr coincident with a saturating output transfer
      ready_mode = 2;
      @(posedge clk);
      #2;
      send(rep4(16'h8100), rep4(16'h1000), 4'd0, rep4(16'h8000), 4'b0000, 4'b1111, 1'b0);
      @(posedge clk);
      #1;
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      ready_mode = 0;
      @(posedge clk);
      #1;
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      chk("sat_clr_priority", 64'(sat_count), 64'd0);
      send(rep4(16'h7F00), rep4(16'hF000), 4'd0, rep4(16'h7FFF), 4'b1111, 4'b0000, 1'b0);
      drain("drain_after_clr");
      chk("sat_count_from_zero", 64'(sat_count), 64'd1);

      // Reset with two vectors in flight
      ready_mode = 2;
      @(posedge clk);
      #2;
      send(rep4(16'h7F00), rep4(16'hF000), 4'd0, rep4(16'h7FFF), 4'b1111, 4'b0000, 1'b0);
      send(rep4(16'h0100), rep4(16'h0200), 4'd1, rep4(16'h0000), 4'b0000, 4'b0000, 1'b0);
      chk("inflight_out_valid", 64'(out_valid), 64'd1);
      #2;
      rst = 1'b1;
      in_valid = 1'b1; x_in = rep4(16'h5555); grad_in = rep4(16'h1111);
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      chk("async_rst_in_ready", 64'(in_ready), 64'd1);
      chk("async_rst_overflow", 64'(overflow), 64'd0);
      chk("async_rst_next_out", next_out, 64'd0);
      chk("async_rst_sat_count", 64'(sat_count), 64'd0);
      sb.delete();
      repeat (3) @(posedge clk);
      #3;
      in_valid = 1'b0;
      #1;
      rst = 1'b0;
      ready_mode = 1;
      @(posedge clk);
      #1;
      send(rep4(16'h0200), rep4(16'h0001), 4'd0, rep4(16'h01FF), 4'b0000, 4'b0000, 1'b1);
      drain("drain_post_reset");
      repeat (4) @(posedge clk);
      #1;
      chk("post_reset_idle", 64'(out_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gd_step_sat.md
GD_STEP_SAT -- requirements
Module: gd_step_sat

Interface
REQ-001 Parameter WIDTH, default 16, total bits per fixed-point operand (signed, two's complement).
REQ-002 Parameter FRAC, default 8, fractional bits (default format Q8.8).
REQ-003 Parameter CH, default 4, number of independent channels (vector dimensions).
REQ-004 Parameter EPS, default 1, convergence threshold in LSBs, unsigned.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  input vector present.
REQ-008 in_ready  output  1  block accepts the input vector this cycle.
REQ-009 x_in  input  CH*WIDTH  current point, channel k at bits [k*WIDTH +: WIDTH].
REQ-010 grad_in  input  CH*WIDTH  gradient, same packing as x_in.
REQ-011 lr_shift  input  4  learning rate as a right shift (step = grad >>> lr_shift), sampled with the input vector.
REQ-012 out_valid  output  1  result vector present.
REQ-013 out_ready  input  1  downstream accepts the result vector.
REQ-014 next_out  output  CH*WIDTH  saturated next point, same packing.
REQ-015 overflow  output  CH  per-channel positive saturation flag for the presented result.
REQ-016 underflow  output  CH  per-channel negative saturation flag for the presented result.
REQ-017 converged  output  1  every channel satisfies |step| <= EPS for the presented result.
REQ-018 sat_count  output  16  number of accepted results with any channel saturated.
REQ-019 sat_clr  input  1  synchronous clear of sat_count.

Function
REQ-020 The datapath SHALL be a 2-stage pipeline: S1 registers x and step = grad >>> lr_shift (arithmetic shift, truncation toward minus infinity); S2 registers saturated x - step with flags.
REQ-021 Latency from input handshake to out_valid SHALL be exactly 2 cycles when out_ready stays high.
REQ-022 Throughput SHALL be one vector per cycle when out_ready stays high.
REQ-023 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-024 A stage SHALL advance when it is empty or the stage after it is advancing; in_ready = S1 empty or S1 advancing (combinational from out_ready, no skid buffer).
REQ-025 While out_valid && !out_ready, next_out, flags and converged SHALL hold stable.
REQ-026 Subtraction SHALL be performed in WIDTH+1 bits; result > 2^(WIDTH-1)-1 sets overflow[k] and outputs 2^(WIDTH-1)-1; result < -2^(WIDTH-1) sets underflow[k] and outputs -2^(WIDTH-1); otherwise outputs the low WIDTH bits.
REQ-027 overflow[k] and underflow[k] SHALL never both be set.
REQ-028 lr_shift = 0 SHALL use the full gradient; lr_shift >= WIDTH-1 SHALL yield step 0 for non-negative grad and -1 for negative grad.
REQ-029 |step| for step = -2^(WIDTH-1) SHALL be treated as 2^(WIDTH-1) (no wrap) in the convergence compare.
REQ-030 converged SHALL be computed from S1 step values and registered alongside S2 data.
REQ-031 sat_count SHALL increment by 1 on each output transfer with any overflow or underflow bit set, and SHALL stick at 16'hFFFF.
REQ-032 sat_clr SHALL force sat_count to 0 on the next edge, taking priority over a simultaneous increment.
REQ-033 Channels SHALL be fully independent; no cross-channel arithmetic except the converged AND and the sat_count OR.

Reset
REQ-034 On rst, S1 and S2 valid bits, out_valid, overflow, underflow, converged and sat_count SHALL go to 0 immediately, without waiting for a clock edge.
REQ-035 next_out SHALL reset to 0.
REQ-036 in_ready SHALL be 1 while rst is high, and the block SHALL ignore in_valid during reset.
REQ-037 Reset mid-transfer SHALL discard all in-flight vectors; no stale vector SHALL appear after reset release.

Verification
REQ-038 Default params, x=0x0100 (1.0), grad=0x0200, lr_shift=1, all channels -> 2 cycles later next_out=0x0000 per channel, flags 0, converged 0.
REQ-039 x=0x7F00, grad=0xF000 (-16.0), lr_shift=0 -> next_out=0x7FFF, overflow=1; x=0x8100, grad=0x1000 -> 0x8000, underflow=1; sat_count increments once per vector.
REQ-040 grad=0x8000, lr_shift=15 -> step=-1, next_out=x+1; grad=0x0001, lr_shift=0, EPS=1 on all channels -> converged=1; one channel grad=0x0002 -> converged=0.
REQ-041 Stream 8 vectors with out_ready toggling 1/0 each cycle -> all 8 results delivered in order, none lost or duplicated, held stable while stalled.
REQ-042 sat_count preloaded to 0xFFFF by saturating traffic -> stays 0xFFFF; sat_clr with a saturating output transfer in the same cycle -> 0.
REQ-043 Assert rst with 2 vectors in flight -> out_valid=0 immediately; after release, the first out_valid SHALL correspond to the first post-reset input.
